fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Next-PC sequencer for the 5-stage MIPS pipeline. It sits between the hazard unit, the decode/EX resolution logic and the PC register.
- Each cycle it selects the next fetch address from boot, mispredict redirect, resolved jr, predicted-taken branch and sequential PC+4. It drives PC write-enable and the IF/ID flush signals.
- It replaces ad-hoc stall and jr handling with one explicit FSM, and keeps saturating performance counters.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cur_pc  in  32  current PC register value
- stall  in  1  load-use/structural stall from hazard unit
- mispredict  in  1  EX found branch mispredicted (single-cycle pulse)
- redirect_pc  in  32  correct-path address, valid with mispredict
- jr_detect  in  1  ID holds jr/jalr
- jr_ready  in  1  jr source register value available (forwarded or read)
- jr_target  in  32  jr target, valid when jr_ready
- pred_taken  in  1  IF predictor says taken
- pred_target  in  32  predicted target
- pc_we  out  1  PC register load enable
- next_pc  out  32  value to load into PC
- flush_if  out  1  squash the instruction currently in IF/ID
- flush_id  out  1  squash the instruction currently in ID/EX
- fsm_state  out  2  current state, for debug
- stall_cycles  out  CNT_W  cycles with pc_we=0 while in RUN or JR_WAIT, saturating
- redirect_count  out  CNT_W  accepted mispredict redirects, saturating

Interface: reset reset, asynchronous, active-high; clock clk.

Behaviour:
- States (2-bit encoding): BOOT=0, RUN=1, JR_WAIT=2, REDIRECT=3.
- While reset is high:
  - state=BOOT, both counters=0.
  - Outputs: pc_we=0, next_pc=RESET_PC, flush_if=1, flush_id=1.
- BOOT (first cycle after reset release):
  - pc_we=1, next_pc=RESET_PC, flush_if=1, flush_id=0.
  - Next state: RUN.
- Priority in RUN/JR_WAIT, highest first: mispredict > jr resolve > stall > pred_taken > sequential.
- mispredict, in any non-BOOT state:
  - pc_we=1, next_pc={redirect_pc[31:2],2'b00}, flush_if=1, flush_id=1.
  - Next state: REDIRECT.
  - redirect_count increments.
  - Any pending jr is abandoned, because it sits on the wrong path.
- REDIRECT (one bubble cycle, lets the new fetch settle):
  - pc_we=1, next_pc=cur_pc+4, flush_if=0, flush_id=0.
  - Next state: RUN.
  - If mispredict arrives again in this cycle, the mispredict rule applies and the state stays REDIRECT.
- RUN:
  - jr_detect=1 with jr_ready=1: pc_we=1, next_pc={jr_target[31:2],2'b00}, flush_if=1; stay RUN.
  - jr_detect=1 with jr_ready=0: pc_we=0, flush_if=1; go to JR_WAIT.
  - stall=1: pc_we=0, no flush.
  - pred_taken=1: pc_we=1, next_pc=pred_target with low 2 bits forced to 0.
  - Otherwise: pc_we=1, next_pc=cur_pc+4. The add is modulo 2^32 (0xFFFF_FFFC wraps to 0).
- JR_WAIT:
  - jr_ready=0: pc_we=0, flush_if=1 every cycle.
  - jr_ready=1: pc_we=1, next_pc=aligned jr_target, flush_if=1; go to RUN.
  - stall is ignored in JR_WAIT; the ID stage is already frozen by the hazard unit.
- jr_detect and stall high together in RUN: jr wins. PC is held, and the jr is handled per the JR_WAIT rules.
- Outputs pc_we, next_pc and flush_* are combinational from state and inputs. State and counters are registered.
- stall_cycles counts every RUN or JR_WAIT cycle with pc_we=0. Both counters saturate at all-ones.
- All address inputs are treated as word addresses: bits [1:0] are always driven to 0 on next_pc.

Decomposition:
- Shared package: state encoding constants and RESET_PC default.
- Sub-module: sat_counter (width param, inc, clear on reset). It is instantiated twice, for the two performance counters.

Test Plan:
- Reset release: hold reset 3 cycles, release -> BOOT cycle shows pc_we=1, next_pc=0x0000_3000, flush_if=1; then RUN with cur_pc=0x3000 -> next_pc=0x3004.
- Stall: stall=1 for 2 cycles in RUN -> pc_we=0 both cycles, no flush, stall_cycles=2; cycle after -> pc_we=1.
- jr latency: jr_detect=1, jr_ready=0 for 2 cycles, then jr_ready=1, jr_target=0x3042 -> fsm_state=2 during the wait, then pc_we=1, next_pc=0x3040, fsm_state=1.
- Mispredict during JR_WAIT: mispredict=1, redirect_pc=0x3100 -> next_pc=0x3100, flush_if=flush_id=1, state REDIRECT, redirect_count=1; next cycle next_pc=cur_pc+4, then RUN.
- Priority: pred_taken=1 (0x3200), stall=1 and mispredict=1 (0x3300) in the same cycle -> next_pc=0x3300. Repeat without mispredict -> pc_we=0.
- Wrap and saturation: cur_pc=0xFFFF_FFFC -> next_pc=0. Force 2^16 stalls with CNT_W=16 -> stall_cycles holds at 0xFFFF.
- Async reset mid-JR_WAIT -> pc_we=0, state=BOOT and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state encoding and boot address.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      JR_WAIT  = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; cleared asynchronously by reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer: picks the fetch address among boot, redirect, jr, predicted
// branch and PC+4, drives PC write-enable and IF/ID flushes, keeps perf counters.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      cur_pc,
   input  logic             stall,
   input  logic             mispredict,
   input  logic [31:0]      redirect_pc,
   input  logic             jr_detect,
   input  logic             jr_ready,
   input  logic [31:0]      jr_target,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   output logic             pc_we,
   output logic [31:0]      next_pc,
   output logic             flush_if,
   output logic             flush_id,
   output logic [1:0]       fsm_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] seq_pc;
   logic        stall_inc;
   logic        redirect_inc;

   assign seq_pc = word_align(cur_pc + 32'd4);

   always_comb begin
      pc_we        = 1'b0;
      next_pc      = seq_pc;
      flush_if     = 1'b0;
      flush_id     = 1'b0;
      state_nxt    = state;
      redirect_inc = 1'b0;
      if (reset) begin
         next_pc   = word_align(RESET_PC);
         flush_if  = 1'b1;
         flush_id  = 1'b1;
         state_nxt = BOOT;
      end else if (state == BOOT) begin
         pc_we     = 1'b1;
         next_pc   = word_align(RESET_PC);
         flush_if  = 1'b1;
         state_nxt = RUN;
      end else if (mispredict) begin
         // A pending jr is on the wrong path, so it is dropped here.
         pc_we        = 1'b1;
         next_pc      = word_align(redirect_pc);
         flush_if     = 1'b1;
         flush_id     = 1'b1;
         state_nxt    = REDIRECT;
         redirect_inc = 1'b1;
      end else begin
         case (state)
            REDIRECT: begin
               pc_we     = 1'b1;
               state_nxt = RUN;
            end
            JR_WAIT: begin
               flush_if = 1'b1;
               if (jr_ready) begin
                  pc_we     = 1'b1;
                  next_pc   = word_align(jr_target);
                  state_nxt = RUN;
               end
            end
            default: begin
               if (jr_detect) begin
                  flush_if = 1'b1;
                  if (jr_ready) begin
                     pc_we   = 1'b1;
                     next_pc = word_align(jr_target);
                  end else begin
                     state_nxt = JR_WAIT;
                  end
               end else if (stall) begin
                  pc_we = 1'b0;
               end else if (pred_taken) begin
                  pc_we   = 1'b1;
                  next_pc = word_align(pred_target);
               end else begin
                  pc_we = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= BOOT;
      else
         state <= state_nxt;
   end

   assign fsm_state = state;
   assign stall_inc = !reset && !pc_we && ((state == RUN) || (state == JR_WAIT));

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (redirect_inc),
      .count (redirect_count)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// checked against a flag-based behavioural model of the fetch rules.
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] cur_pc;
   logic        stall;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        jr_detect;
   logic        jr_ready;
   logic [31:0] jr_target;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        pc_we;
   logic [31:0] next_pc;
   logic        flush_if;
   logic        flush_id;
   logic [1:0]  fsm_state;
   logic [15:0] stall_cycles;
   logic [15:0] redirect_count;

   int checks = 0;
   int failures = 0;

   fetch_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .cur_pc         (cur_pc),
      .stall          (stall),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .jr_detect      (jr_detect),
      .jr_ready       (jr_ready),
      .jr_target      (jr_target),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .pc_we          (pc_we),
      .next_pc        (next_pc),
      .flush_if       (flush_if),
      .flush_id       (flush_id),
      .fsm_state      (fsm_state),
      .stall_cycles   (stall_cycles),
      .redirect_count (redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: "in reset", "boot pending", "waiting on jr", "settling after redirect".
   bit          m_rst, m_boot, m_jr, m_settle;
   int          m_sc, m_rc;
   bit          n_boot, n_jr, n_settle, n_sc_inc, n_rc_inc;
   bit          e_we, e_fi, e_fd;
   logic [31:0] e_np;
   logic [1:0]  e_st;

   function automatic logic [31:0] al(input logic [31:0] a);
      logic [31:0] r;
      r = a & 32'hFFFF_FFFC;
      return r;
   endfunction

   task automatic model_eval();
      n_boot = m_boot; n_jr = m_jr; n_settle = m_settle; n_sc_inc = 0; n_rc_inc = 0;
      e_we = 0; e_fi = 0; e_fd = 0; e_np = 32'h0;
      if (m_rst || m_boot) e_st = 2'd0;
      else if (m_settle)   e_st = 2'd3;
      else if (m_jr)       e_st = 2'd2;
      else                 e_st = 2'd1;
      if (m_rst) begin
         e_np = 32'h3000; e_fi = 1; e_fd = 1;
      end else if (m_boot) begin
         e_we = 1; e_np = 32'h3000; e_fi = 1; n_boot = 0;
      end else if (mispredict) begin
         e_we = 1; e_np = al(redirect_pc); e_fi = 1; e_fd = 1;
         n_settle = 1; n_jr = 0; n_rc_inc = 1;
      end else if (m_settle) begin
         e_we = 1; e_np = al(cur_pc + 32'd4); n_settle = 0;
      end else if (m_jr || jr_detect) begin
         e_fi = 1;
         if (jr_ready) begin e_we = 1; e_np = al(jr_target); n_jr = 0; end
         else n_jr = 1;
      end else if (stall) begin
         e_we = 0;
      end else if (pred_taken) begin
         e_we = 1; e_np = al(pred_target);
      end else begin
         e_we = 1; e_np = al(cur_pc + 32'd4);
      end
      if (!m_rst && !m_boot && !m_settle && !e_we) n_sc_inc = 1;
   endtask

   task automatic model_commit();
      if (!m_rst) begin
         m_boot = n_boot; m_jr = n_jr; m_settle = n_settle;
         if (n_sc_inc && m_sc < 65535) m_sc++;
         if (n_rc_inc && m_rc < 65535) m_rc++;
      end
   endtask

   task automatic eval_cycle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; mispredict = 0; redirect_pc = 0; jr_detect = 0; jr_ready = 0;
      jr_target = 0; pred_taken = 0; pred_target = 0;
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      reset = 0; m_rst = 0; m_boot = 1; m_jr = 0; m_settle = 0;
   endtask

   task automatic test_reset();
      reset = 1; m_rst = 1; m_sc = 0; m_rc = 0; cur_pc = 32'h0;
      clear_inputs();
      repeat (3) @(posedge clk);
      eval_cycle();
      checks++;
      if ({pc_we, flush_if, flush_id, fsm_state} !== 5'b0_1_1_00 || next_pc !== 32'h3000 ||
          stall_cycles !== 16'd0 || redirect_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_hold: we=%b fi=%b fd=%b st=%0d np=%h sc=%0d rc=%0d, want 0 1 1 0 00003000 0 0",
                  pc_we, flush_if, flush_id, fsm_state, next_pc, stall_cycles, redirect_count);
      end
      release_reset();
      eval_cycle();
      checks++;
      if ({pc_we, flush_if, flush_id, fsm_state} !== 5'b1_1_0_00 || next_pc !== 32'h3000) begin
         failures++;
         $display("FAIL boot_cycle: we=%b fi=%b fd=%b st=%0d np=%h, want 1 1 0 0 00003000",
                  pc_we, flush_if, flush_id, fsm_state, next_pc);
      end
      advance();
      cur_pc = 32'h3000;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b1 || next_pc !== 32'h3004 || fsm_state !== 2'd1) begin
         failures++;
         $display("FAIL first_seq: we=%b np=%h st=%0d, want 1 00003004 1", pc_we, next_pc, fsm_state);
      end
      advance();
   endtask

   task automatic test_stall();
      cur_pc = 32'h3004; stall = 1;
      for (int i = 0; i < 2; i++) begin
         eval_cycle();
         checks++;
         if (pc_we !== 1'b0 || flush_if !== 1'b0 || flush_id !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d: we=%b fi=%b fd=%b, want 0 0 0", i, pc_we, flush_if, flush_id);
         end
         advance();
      end
      stall = 0;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b1 || next_pc !== 32'h3008 || stall_cycles !== 16'd2 || stall_cycles !== m_sc[15:0]) begin
         failures++;
         $display("FAIL stall_release: we=%b np=%h sc=%0d, want 1 00003008 2", pc_we, next_pc, stall_cycles);
      end
      advance();
   endtask

   task automatic test_jr_latency();
      cur_pc = 32'h3010; jr_detect = 1; jr_ready = 0; jr_target = 32'h3042;
      for (int i = 0; i < 2; i++) begin
         eval_cycle();
         checks++;
         if (pc_we !== 1'b0 || flush_if !== 1'b1 || fsm_state !== e_st || (i == 1 && fsm_state !== 2'd2)) begin
            failures++;
            $display("FAIL jr_wait%0d: we=%b fi=%b st=%0d, want 0 1 %0d", i, pc_we, flush_if, fsm_state, e_st);
         end
         advance();
      end
      jr_ready = 1;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b1 || next_pc !== 32'h3040 || flush_if !== 1'b1 || fsm_state !== 2'd2) begin
         failures++;
         $display("FAIL jr_resolve: we=%b np=%h fi=%b st=%0d, want 1 00003040 1 2", pc_we, next_pc, flush_if, fsm_state);
      end
      advance();
      jr_detect = 0; jr_ready = 0; cur_pc = 32'h3040;
      eval_cycle();
      checks++;
      if (fsm_state !== 2'd1 || pc_we !== 1'b1 || next_pc !== 32'h3044) begin
         failures++;
         $display("FAIL jr_back_run: st=%0d we=%b np=%h, want 1 1 00003044", fsm_state, pc_we, next_pc);
      end
      advance();
   endtask

   task automatic test_mispredict_jr_wait();
      jr_detect = 1; jr_ready = 0; jr_target = 32'h3500;
      eval_cycle(); advance();
      mispredict = 1; redirect_pc = 32'h3100;
      eval_cycle();
      checks++;
      if ({pc_we, flush_if, flush_id, fsm_state} !== 5'b1_1_1_10 || next_pc !== 32'h3100) begin
         failures++;
         $display("FAIL mp_in_jr: we=%b fi=%b fd=%b st=%0d np=%h, want 1 1 1 2 00003100",
                  pc_we, flush_if, flush_id, fsm_state, next_pc);
      end
      advance();
      mispredict = 0; jr_detect = 0; cur_pc = 32'h3100;
      eval_cycle();
      checks++;
      if ({pc_we, flush_if, flush_id, fsm_state} !== 5'b1_0_0_11 || next_pc !== 32'h3104 ||
          redirect_count !== 16'd1) begin
         failures++;
         $display("FAIL mp_bubble: we=%b fi=%b fd=%b st=%0d np=%h rc=%0d, want 1 0 0 3 00003104 1",
                  pc_we, flush_if, flush_id, fsm_state, next_pc, redirect_count);
      end
      advance();
      cur_pc = 32'h3104;
      eval_cycle();
      checks++;
      if (fsm_state !== 2'd1 || pc_we !== 1'b1 || next_pc !== 32'h3108) begin
         failures++;
         $display("FAIL mp_back_run: st=%0d we=%b np=%h, want 1 1 00003108", fsm_state, pc_we, next_pc);
      end
      advance();
   endtask

   task automatic test_priority();
      pred_taken = 1; pred_target = 32'h3200; stall = 1; mispredict = 1; redirect_pc = 32'h3300;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b1 || next_pc !== 32'h3300 || flush_id !== 1'b1) begin
         failures++;
         $display("FAIL prio_mp: we=%b np=%h fd=%b, want 1 00003300 1", pc_we, next_pc, flush_id);
      end
      advance();
      redirect_pc = 32'h3402;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b1 || next_pc !== 32'h3400 || fsm_state !== 2'd3 || flush_id !== 1'b1) begin
         failures++;
         $display("FAIL prio_mp_in_redirect: we=%b np=%h st=%0d fd=%b, want 1 00003400 3 1",
                  pc_we, next_pc, fsm_state, flush_id);
      end
      advance();
      mispredict = 0; stall = 0; pred_taken = 0; cur_pc = 32'h3400;
      eval_cycle();
      checks++;
      if (fsm_state !== 2'd3 || next_pc !== 32'h3404 || redirect_count !== m_rc[15:0]) begin
         failures++;
         $display("FAIL prio_settle: st=%0d np=%h rc=%0d, want 3 00003404 %0d", fsm_state, next_pc, redirect_count, m_rc);
      end
      advance();
      pred_taken = 1; stall = 1;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b0 || flush_if !== 1'b0) begin
         failures++;
         $display("FAIL prio_stall_over_pred: we=%b fi=%b, want 0 0", pc_we, flush_if);
      end
      advance();
      stall = 0; pred_target = 32'h3203;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b1 || next_pc !== 32'h3200) begin
         failures++;
         $display("FAIL pred_align: we=%b np=%h, want 1 00003200", pc_we, next_pc);
      end
      advance();
      pred_taken = 0;
   endtask

   task automatic test_wrap();
      cur_pc = 32'hFFFF_FFFC;
      eval_cycle();
      checks++;
      if (pc_we !== 1'b1 || next_pc !== 32'h0000_0000) begin
         failures++;
         $display("FAIL pc_wrap: we=%b np=%h, want 1 00000000", pc_we, next_pc);
      end
      advance();
      cur_pc = 32'h3000;
   endtask

   task automatic test_saturation();
      stall = 1;
      repeat (65540) begin
         eval_cycle(); advance();
      end
      eval_cycle();
      checks++;
      if (stall_cycles !== 16'hFFFF || m_sc != 65535 || pc_we !== 1'b0) begin
         failures++;
         $display("FAIL stall_saturate: sc=%h we=%b, want ffff 0", stall_cycles, pc_we);
      end
      advance();
      stall = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         cur_pc      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
         mispredict  = ($urandom_range(0, 7) == 0);
         redirect_pc = $urandom;
         jr_detect   = ($urandom_range(0, 3) == 0);
         jr_ready    = ($urandom_range(0, 1) == 0);
         jr_target   = $urandom;
         stall       = ($urandom_range(0, 3) == 0);
         pred_taken  = ($urandom_range(0, 2) == 0);
         pred_target = $urandom;
         eval_cycle();
         checks++;
         if ({pc_we, flush_if, flush_id, fsm_state} !== {e_we, e_fi, e_fd, e_st} ||
             (e_we && next_pc !== e_np) || stall_cycles !== m_sc[15:0] || redirect_count !== m_rc[15:0]) begin
            failures++;
            $display("FAIL random%0d: we=%b fi=%b fd=%b st=%0d np=%h sc=%0d rc=%0d, want %b %b %b %0d %h %0d %0d",
                     i, pc_we, flush_if, flush_id, fsm_state, next_pc, stall_cycles, redirect_count,
                     e_we, e_fi, e_fd, e_st, e_np, m_sc, m_rc);
         end
         advance();
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      jr_ready = 1;
      eval_cycle(); advance();
      jr_ready = 0; jr_detect = 1; jr_target = 32'h3080;
      eval_cycle(); advance();
      eval_cycle();
      checks++;
      if (fsm_state !== 2'd2) begin
         failures++;
         $display("FAIL ar_setup: st=%0d, want 2", fsm_state);
      end
      #2;
      reset = 1; m_rst = 1; m_sc = 0; m_rc = 0;
      #1;
      checks++;
      if ({pc_we, flush_if, flush_id, fsm_state} !== 5'b0_1_1_00 || stall_cycles !== 16'd0 ||
          redirect_count !== 16'd0 || next_pc !== 32'h3000) begin
         failures++;
         $display("FAIL async_reset: we=%b fi=%b fd=%b st=%0d np=%h sc=%0d rc=%0d, want 0 1 1 0 00003000 0 0",
                  pc_we, flush_if, flush_id, fsm_state, next_pc, stall_cycles, redirect_count);
      end
      clear_inputs();
      release_reset();
      eval_cycle();
      checks++;
      if ({pc_we, flush_if, flush_id, fsm_state} !== 5'b1_1_0_00 || next_pc !== 32'h3000) begin
         failures++;
         $display("FAIL reboot: we=%b fi=%b fd=%b st=%0d np=%h, want 1 1 0 0 00003000",
                  pc_we, flush_if, flush_id, fsm_state, next_pc);
      end
      advance();
   endtask

   initial begin
      test_reset();
      test_stall();
      test_jr_latency();
      test_mispredict_jr_wait();
      test_priority();
      test_wrap();
      test_saturation();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
